// File: rtl/calc_sequencer_if.sv
// Signal bundle between the calculator sequencer and its environment:
// buttons/switches in, ALU handshake out/in, and display/status outputs.
interface calc_sequencer_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RES_W  = 8
);
    logic [3:0]        btn_i;
    logic [7:0]        sw_i;
    logic              alu_busy_i;
    logic [RES_W-1:0]  alu_res_i;
    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    logic [3:0]        alu_op_o;
    logic              alu_start_o;
    logic [15:0]       seg_num_o;
    logic              led_o;
    logic              err_o;

    // The sequencer drives the ALU and display side.
    modport master (
        input  btn_i, sw_i, alu_busy_i, alu_res_i,
        output alu_a_o, alu_b_o, alu_op_o, alu_start_o, seg_num_o, led_o, err_o
    );

    modport slave (
        output btn_i, sw_i, alu_busy_i, alu_res_i,
        input  alu_a_o, alu_b_o, alu_op_o, alu_start_o, seg_num_o, led_o, err_o
    );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencing controller for the multi-cycle calculator ALU: operand/op capture,
// start pulse, busy wait with timeout, result latch and display value.
module calc_sequencer #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned RES_W    = 8,
    parameter int unsigned OP_COUNT = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic            clk,
    input logic            rst,
    calc_sequencer_if.master bus
);

    localparam int unsigned OpW  = $clog2(OP_COUNT);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [OpW-1:0]  OpMax  = OpW'(OP_COUNT - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWait, StRun, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OpW-1:0]    op_q, op_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              wait_q, wait_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        op_ext;
    logic [15:0]       seg;
    logic              unused_sw;

    assign unused_sw = ^bus.sw_i[7:DATA_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            wait_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                // Execute wins over any load/op press in the same cycle.
                if (bus.btn_i[3]) begin
                    state_d = StIssue;
                end else begin
                    if (bus.btn_i[0]) a_d = bus.sw_i[DATA_W-1:0];
                    if (bus.btn_i[1]) b_d = bus.sw_i[DATA_W-1:0];
                    if (bus.btn_i[2]) op_d = (op_q == OpMax) ? '0 : op_q + 1'b1;
                    if (state_q == StDone && |bus.btn_i[2:0]) state_d = StIdle;
                end
            end
            StIssue: begin
                state_d = StWait;
                wait_d  = 1'b0;
            end
            StWait: begin
                if (bus.alu_busy_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (wait_q) begin
                    // Busy never rose: treat as a single-cycle ALU.
                    res_d   = bus.alu_res_i;
                    state_d = StDone;
                end else begin
                    wait_d = 1'b1;
                end
            end
            StRun: begin
                if (!bus.alu_busy_i) begin
                    res_d   = bus.alu_res_i;
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StErr: begin
                if (|bus.btn_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign op_ext = 4'(op_q);

    always_comb begin
        seg = 16'h0000;
        unique case (state_q)
            StIdle, StIssue, StWait, StRun: seg = 16'({a_q, b_q, op_ext, 4'h0});
            StDone:                         seg = {4'h0, op_ext, res_q[7:0]};
            StErr:                          seg = 16'hEEEE;
            default:                        seg = 16'h0000;
        endcase
    end

    assign bus.alu_a_o     = a_q;
    assign bus.alu_b_o     = b_q;
    assign bus.alu_op_o    = op_ext;
    assign bus.alu_start_o = (state_q == StIssue);
    assign bus.led_o       = (state_q == StIssue) || (state_q == StWait) || (state_q == StRun);
    assign bus.err_o       = (state_q == StErr);
    assign bus.seg_num_o   = seg;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the calculator's multi-cycle ALU. It captures two 4-bit operands and an operation code from the switch bank under button control, issues a one-cycle start to the ALU, and waits out the ALU's busy window with a timeout. It then latches the result and drives the 16-bit number shown by the seven-segment driver. It sits between the debounced button/switch synchronisers and the ALU/display blocks.

## Interface

- DATA_W, 4, operand width (alu_a_o, alu_b_o)
- RES_W, 8, ALU result width
- OP_COUNT, 8, number of selectable operations; op code range 0..OP_COUNT-1
- TIMEOUT, 255, maximum cycles in RUN before error
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- btn_i  in  4  one-cycle pulses from the button debouncer: [0] load A, [1] load B, [2] next op, [3] execute
- sw_i  in  8  synchronised switches; operand value is sw_i[3:0]
- alu_busy_i  in  1  ALU busy flag
- alu_res_i  in  RES_W  ALU result; valid in the cycle busy deasserts
- alu_a_o  out  DATA_W  operand A to ALU
- alu_b_o  out  DATA_W  operand B to ALU
- alu_op_o  out  4  operation code to ALU (zero-extended op register)
- alu_start_o  out  1  one-cycle start pulse
- seg_num_o  out  16  four hex digits to the display driver
- led_o  out  1  high while an operation is in flight
- err_o  out  1  sticky timeout flag

## Operation

- States: IDLE, ISSUE, WAIT, RUN, DONE, ERR.
- IDLE and DONE accept buttons. btn_i[3] has priority. If it is set, the other bits in that cycle are ignored and the FSM goes to ISSUE. Otherwise, in the same cycle:
  - [0] loads A from sw_i[3:0].
  - [1] loads B from sw_i[3:0].
  - [2] increments op, wrapping OP_COUNT-1 -> 0.
  - In DONE, any of [0..2] also moves the FSM to IDLE.
  - Execute in DONE re-runs with the current A, B and op.
- ISSUE: alu_start_o=1 for exactly this cycle. Next state is WAIT with the wait counter cleared.
- WAIT:
  - busy=1 -> RUN, with the timeout counter cleared.
  - busy=0 for 2 consecutive WAIT cycles -> single-cycle ALU: capture alu_res_i in the second cycle, go to DONE.
- RUN:
  - busy=0 -> capture alu_res_i this cycle, go to DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, go to ERR and set err_o.
- ERR: result register unchanged. Any nonzero btn_i clears err_o and goes to IDLE; that pulse is otherwise ignored.
- Buttons pressed in ISSUE, WAIT or RUN are dropped, not queued.
- alu_a_o, alu_b_o and alu_op_o come from registers. Loads are blocked outside IDLE/DONE, so these outputs are stable from ISSUE to DONE.
- seg_num_o by state:
  - IDLE: {A, B, op[3:0], 4'h0}.
  - ISSUE, WAIT, RUN: the IDLE value, frozen.
  - DONE: {4'h0, op[3:0], result[7:0]}.
  - ERR: 16'hEEEE.
- led_o = 1 in ISSUE, WAIT and RUN; 0 otherwise.

## Timing

- Reset (rst=0 at a clock edge):
  - State = IDLE.
  - A, B, op, result and both counters = 0.
  - alu_start_o=0, led_o=0, err_o=0, seg_num_o=16'h0000.
  - Reset has priority over every event, including mid-RUN. The ALU is reset by the same rst.
- Execute pulse in cycle N -> alu_start_o high in cycle N+1 (ISSUE). WAIT starts in cycle N+2.
- Multi-cycle ALU with busy high from N+2 and low at cycle M -> result registered at the M edge. State is DONE and seg_num_o is updated from cycle M+1.
- Single-cycle ALU (busy never asserts) -> DONE from cycle N+4.
- Timeout: ERR is entered one cycle after the RUN cycle in which the counter equals TIMEOUT. Counter width is ceil(log2(TIMEOUT+1)).
- All outputs are registered or decoded from the state register; there is no combinational path from btn_i or alu_busy_i to any output.

## Test plan

- Reset, then btn[0] with sw=8'h05, btn[1] with sw=8'h03, btn[2] twice -> seg_num_o=16'h5320, alu_op_o=2, led_o=0.
- A=5, B=3, op=1, execute; model ALU busy for 4 cycles, then result 8'h0F -> exactly one start pulse, led_o high through RUN, seg_num_o=16'h010F in DONE.
- btn[2] pressed OP_COUNT+1 times from op=0 -> op=1 (wrap). btn_i=4'b1011 in IDLE -> ISSUE entered with A and B unchanged.
- ALU held busy permanently -> after TIMEOUT cycles err_o=1 and seg_num_o=16'hEEEE. Any button -> IDLE with err_o=0.
- Button pulses during RUN -> A, B and op unchanged, no extra start. rst=0 mid-RUN -> next cycle all outputs at reset values.
- Busy never asserts after start (single-cycle ALU), alu_res_i=8'hA5 -> DONE at N+4, seg_num_o low byte = 8'hA5.
